// File: rtl/sb_arb_if.sv
// rtl/sb_arb_if.sv - request/response and memory-side bundle for the sb_arb arbiter
interface sb_arb_if #(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32
);
   logic [NUM_M-1:0]        m_req;
   logic [NUM_M-1:0]        m_we;
   logic [2*NUM_M-1:0]      m_size;
   logic [NUM_M-1:0]        m_unsigned;
   logic [NUM_M*ADDR_W-1:0] m_addr;
   logic [32*NUM_M-1:0]     m_wdata;
   logic [NUM_M-1:0]        m_gnt;
   logic [NUM_M-1:0]        m_rvalid;
   logic [31:0]             m_rdata;
   logic [NUM_M-1:0]        m_err;

   logic                    s_req;
   logic                    s_we;
   logic [3:0]              s_be;
   logic [ADDR_W-1:0]       s_addr;
   logic [31:0]             s_wdata;
   logic [31:0]             s_rdata;

   // slave is the arbiter's own view: it serves the masters and drives the memory
   modport slave (
      input  m_req, m_we, m_size, m_unsigned, m_addr, m_wdata, s_rdata,
      output m_gnt, m_rvalid, m_rdata, m_err, s_req, s_we, s_be, s_addr, s_wdata
   );

   modport master (
      output m_req, m_we, m_size, m_unsigned, m_addr, m_wdata, s_rdata,
      input  m_gnt, m_rvalid, m_rdata, m_err, s_req, s_we, s_be, s_addr, s_wdata
   );
endinterface

// File: rtl/sb_arb.sv
// rtl/sb_arb.sv - NUM_M-master system-bus arbiter onto one synchronous memory port
module sb_arb #(
   parameter int NUM_M    = 2,
   parameter int ADDR_W   = 32,
   parameter int ARB_MODE = 1
) (
   input  logic    clk,
   input  logic    rst,
   sb_arb_if.slave bus
);
   localparam int         IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [IDX_W:0] NUM_L = (IDX_W + 1)'(NUM_M);

   typedef struct packed {
      logic             v;
      logic [IDX_W-1:0] idx;
      logic [1:0]       size;
      logic [1:0]       k;
      logic             uns;
   } tag_t;

   logic [NUM_M-1:0]  req_live;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [IDX_W-1:0]  gnt_idx;
   logic              gnt_any;
   logic [NUM_M-1:0]  gnt_oh;
   logic [IDX_W:0]    cand;

   logic              sel_we;
   logic              sel_uns;
   logic [1:0]        sel_size;
   logic [ADDR_W-1:0] sel_addr;
   logic [31:0]       sel_wdata;
   logic [1:0]        lane_k;
   logic              misal;
   logic              legal;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata;

   logic              s_req_q, s_req_d;
   logic              s_we_q, s_we_d;
   logic [3:0]        s_be_q, s_be_d;
   logic [ADDR_W-1:0] s_addr_q, s_addr_d;
   logic [31:0]       s_wdata_q, s_wdata_d;
   logic [NUM_M-1:0]  err_q, err_d;
   tag_t              tag1_q, tag1_d;
   tag_t              tag2_q;
   logic [NUM_M-1:0]  rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [31:0]       rd_lane;

   // Requests are ignored while reset is held so m_gnt stays low.
   assign req_live = rst ? bus.m_req : '0;

   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = '0;
      if (ARB_MODE == 0) begin
         for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req_live[i]) begin
               gnt_idx = IDX_W'(i);
               gnt_any = 1'b1;
            end
         end
      end else begin
         // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
         for (int off = NUM_M; off >= 1; off--) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(off);
            if (cand >= NUM_L) begin
               cand = cand - NUM_L;
            end
            if (req_live[cand[IDX_W-1:0]]) begin
               gnt_idx = cand[IDX_W-1:0];
               gnt_any = 1'b1;
            end
         end
      end
   end

   assign gnt_oh = gnt_any ? (NUM_M'(1) << gnt_idx) : '0;
   assign ptr_d  = gnt_any ? gnt_idx : ptr_q;

   always_comb begin
      sel_we    = 1'b0;
      sel_uns   = 1'b0;
      sel_size  = 2'b00;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (gnt_idx == IDX_W'(i)) begin
            sel_we    = bus.m_we[i];
            sel_uns   = bus.m_unsigned[i];
            sel_size  = bus.m_size[2*i +: 2];
            sel_addr  = bus.m_addr[ADDR_W*i +: ADDR_W];
            sel_wdata = bus.m_wdata[32*i +: 32];
         end
      end
   end

   assign lane_k = sel_addr[1:0];
   assign misal  = (sel_size == 2'b11)
                || ((sel_size == SZ_HALF) && sel_addr[0])
                || ((sel_size == SZ_WORD) && (sel_addr[1:0] != 2'b00));
   assign legal  = gnt_any && !misal;

   always_comb begin
      case (sel_size)
         SZ_BYTE: begin
            lane_be    = 4'b0001 << lane_k;
            lane_wdata = {4{sel_wdata[7:0]}};
         end
         SZ_HALF: begin
            lane_be    = 4'b0011 << lane_k;
            lane_wdata = {2{sel_wdata[15:0]}};
         end
         default: begin
            lane_be    = 4'b1111;
            lane_wdata = sel_wdata;
         end
      endcase
   end

   always_comb begin
      s_req_d     = legal;
      s_we_d      = legal && sel_we;
      s_be_d      = legal ? lane_be : 4'b0000;
      s_addr_d    = legal ? {sel_addr[ADDR_W-1:2], 2'b00} : '0;
      s_wdata_d   = (legal && sel_we) ? lane_wdata : 32'h0;
      err_d       = (gnt_any && misal) ? gnt_oh : '0;
      tag1_d.v    = legal && !sel_we;
      tag1_d.idx  = gnt_idx;
      tag1_d.size = sel_size;
      tag1_d.k    = lane_k;
      tag1_d.uns  = sel_uns;
   end

   // Stage 2 lines up with the memory's read data; pick the lane and extend it.
   always_comb begin
      rd_lane = bus.s_rdata >> {tag2_q.k, 3'b000};
      case (tag2_q.size)
         SZ_BYTE: rdata_d = {{24{!tag2_q.uns && rd_lane[7]}}, rd_lane[7:0]};
         SZ_HALF: rdata_d = {{16{!tag2_q.uns && rd_lane[15]}}, rd_lane[15:0]};
         default: rdata_d = rd_lane;
      endcase
      rvalid_d = tag2_q.v ? (NUM_M'(1) << tag2_q.idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ptr_q     <= IDX_W'(NUM_M - 1);
         s_req_q   <= 1'b0;
         s_we_q    <= 1'b0;
         s_be_q    <= 4'b0000;
         s_addr_q  <= '0;
         s_wdata_q <= 32'h0;
         err_q     <= '0;
         tag1_q    <= '0;
         tag2_q    <= '0;
         rvalid_q  <= '0;
         rdata_q   <= 32'h0;
      end else begin
         ptr_q     <= ptr_d;
         s_req_q   <= s_req_d;
         s_we_q    <= s_we_d;
         s_be_q    <= s_be_d;
         s_addr_q  <= s_addr_d;
         s_wdata_q <= s_wdata_d;
         err_q     <= err_d;
         tag1_q    <= tag1_d;
         tag2_q    <= tag1_q;
         rvalid_q  <= rvalid_d;
         if (tag2_q.v) begin
            rdata_q <= rdata_d;
         end
      end
   end

   assign bus.m_gnt    = gnt_oh;
   assign bus.m_rvalid = rvalid_q;
   assign bus.m_rdata  = rdata_q;
   assign bus.m_err    = err_q;
   assign bus.s_req    = s_req_q;
   assign bus.s_we     = s_we_q;
   assign bus.s_be     = s_be_q;
   assign bus.s_addr   = s_addr_q;
   assign bus.s_wdata  = s_wdata_q;
endmodule
